// File: rtl/video_scan.sv
// 640x480@60 text-mode raster generator: 80x25 character page, 8x16 cells,
// video RAM -> font ROM -> 1-bit pixel pipeline with reverse video and blinking cursor.
module video_scan (
  input  logic        clk,
  input  logic        reset_n,
  output logic [11:0] video_addr,
  input  logic [7:0]  video_data,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  input  logic [11:0] cursor_addr,
  input  logic        cursor_en,
  output logic        pixel,
  output logic        hsync_n,
  output logic        vsync_n,
  output logic        blank
);

  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic [5:0]  frame;

  logic        h_last;
  logic        v_last;
  logic        text_area;
  logic [11:0] row_ext;
  logic [11:0] col_ext;
  logic        hs_now;
  logic        vs_now;
  logic        bl_now;

  logic [11:0] addr_d;
  logic        inv_q;
  logic        hit_q;
  logic [7:0]  shift_reg;
  logic        inv_px;
  logic        cur_px;

  logic [3:0]  hs_dly;
  logic [3:0]  vs_dly;
  logic [3:0]  bl_dly;
  logic [3:0]  txt_dly;

  assign h_last = (h_cnt == 10'd799);
  assign v_last = (v_cnt == 10'd524);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
      frame <= '0;
    end else begin
      if (h_last) begin
        h_cnt <= '0;
        if (v_last) begin
          v_cnt <= '0;
          frame <= frame + 6'd1;
        end else begin
          v_cnt <= v_cnt + 10'd1;
        end
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  always_comb begin
    text_area = (v_cnt < 10'd400) && (h_cnt < 10'd640);
    row_ext   = {7'd0, v_cnt[8:4]};
    col_ext   = {5'd0, h_cnt[9:3]};
    video_addr = '0;
    if (text_area)
      video_addr = (row_ext << 6) + (row_ext << 4) + col_ext;
    hs_now = !((h_cnt >= 10'd656) && (h_cnt <= 10'd751));
    vs_now = !((v_cnt == 10'd490) || (v_cnt == 10'd491));
    bl_now = (h_cnt >= 10'd640) || (v_cnt >= 10'd480);
  end

  // Sync/blank/text-area ride a 4-deep delay line so they line up with the pixel stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_dly  <= '1;
      vs_dly  <= '1;
      bl_dly  <= '1;
      txt_dly <= '0;
    end else begin
      hs_dly  <= {hs_dly[2:0], hs_now};
      vs_dly  <= {vs_dly[2:0], vs_now};
      bl_dly  <= {bl_dly[2:0], bl_now};
      txt_dly <= {txt_dly[2:0], text_area};
    end
  end

  // Character stage captures at cell phase 1; the glyph row loads at phase 3 so
  // it is on screen from phase 4, and the cell's attributes travel with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_d    <= '0;
      font_addr <= '0;
      inv_q     <= 1'b0;
      hit_q     <= 1'b0;
      shift_reg <= '0;
      inv_px    <= 1'b0;
      cur_px    <= 1'b0;
    end else begin
      addr_d <= video_addr;
      if (h_cnt[2:0] == 3'd1) begin
        font_addr <= {video_data[6:0], v_cnt[3:0]};
        inv_q     <= video_data[7];
        hit_q     <= (addr_d == cursor_addr) && cursor_en && frame[4]
                     && (v_cnt[3:0] >= 4'd14);
      end
      if (h_cnt[2:0] == 3'd3) begin
        shift_reg <= font_data;
        inv_px    <= inv_q;
        cur_px    <= hit_q;
      end else begin
        shift_reg <= {shift_reg[6:0], 1'b0};
      end
    end
  end

  assign pixel   = txt_dly[3] & (shift_reg[7] ^ inv_px ^ cur_px);
  assign hsync_n = hs_dly[3];
  assign vsync_n = vs_dly[3];
  assign blank   = bl_dly[3];

endmodule

// File: tb/tb_video_scan.sv
// Directed bench for video_scan: RAM/ROM models, table of address/sync vectors,
// hand-written glyph, reverse-video, cursor, wrap and reset sequences.
module tb_video_scan;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] video_addr;
  logic [7:0]  video_data;
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  logic [11:0] cursor_addr;
  logic        cursor_en;
  logic        pixel;
  logic        hsync_n;
  logic        vsync_n;
  logic        blank;

  logic [7:0] vram [0:4095];
  logic [7:0] font [0:2047];

  int tests = 0;
  int fails = 0;

  video_scan dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .video_addr  (video_addr),
    .video_data  (video_data),
    .font_addr   (font_addr),
    .font_data   (font_data),
    .cursor_addr (cursor_addr),
    .cursor_en   (cursor_en),
    .pixel       (pixel),
    .hsync_n     (hsync_n),
    .vsync_n     (vsync_n),
    .blank       (blank)
  );

  always #20 clk = ~clk;

  always @(posedge clk) begin
    video_data <= vram[video_addr];
    font_data  <= font[font_addr];
  end

  typedef struct {
    int          h;
    int          v;
    logic [11:0] addr;
    logic        hs;
    logic        vs;
    logic        bl;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic preset(input int h, input int v, input int f);
    logic [9:0] hh;
    logic [9:0] vv;
    logic [5:0] ff;
    hh = h[9:0];
    vv = v[9:0];
    ff = f[5:0];
    @(negedge clk);
    dut.h_cnt = hh;
    dut.v_cnt = vv;
    dut.frame = ff;
    #1;
  endtask

  // Called in cycle 0 (h=0); checks pixel for cycles 4..19 (cells 0 and 1).
  task automatic check_cell(input logic [15:0] exp, input string name);
    for (int k = 1; k < 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k >= 4) check($sformatf("%s px%0d", name, k), {31'd0, pixel}, {31'd0, exp[19-k]});
    end
  endtask

  task automatic cell_test(input int v, input int f, input logic [15:0] exp, input string name);
    preset(0, v, f);
    check_cell(exp, name);
  endtask

  initial begin
    int n;
    int cnt0;
    int cnt1;
    int cnt2;

    vecs[0]  = '{0,   0,   12'd0,    1'b1, 1'b1, 1'b0};
    vecs[1]  = '{40,  16,  12'd85,   1'b1, 1'b1, 1'b0};
    vecs[2]  = '{300, 100, 12'd517,  1'b1, 1'b1, 1'b0};
    vecs[3]  = '{639, 399, 12'd1999, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{640, 399, 12'd0,    1'b1, 1'b1, 1'b1};
    vecs[5]  = '{0,   400, 12'd0,    1'b1, 1'b1, 1'b0};
    vecs[6]  = '{655, 10,  12'd0,    1'b1, 1'b1, 1'b1};
    vecs[7]  = '{656, 10,  12'd0,    1'b0, 1'b1, 1'b1};
    vecs[8]  = '{751, 10,  12'd0,    1'b0, 1'b1, 1'b1};
    vecs[9]  = '{752, 10,  12'd0,    1'b1, 1'b1, 1'b1};
    vecs[10] = '{100, 479, 12'd0,    1'b1, 1'b1, 1'b0};
    vecs[11] = '{100, 480, 12'd0,    1'b1, 1'b1, 1'b1};
    vecs[12] = '{0,   489, 12'd0,    1'b1, 1'b1, 1'b1};
    vecs[13] = '{0,   490, 12'd0,    1'b1, 1'b0, 1'b1};
    vecs[14] = '{799, 491, 12'd0,    1'b1, 1'b0, 1'b1};
    vecs[15] = '{0,   492, 12'd0,    1'b1, 1'b1, 1'b1};
    vecs[16] = '{8,   15,  12'd1,    1'b1, 1'b1, 1'b0};
    vecs[17] = '{632, 384, 12'd1999, 1'b1, 1'b1, 1'b0};

    for (int i = 0; i < 4096; i++) vram[i] = 8'h00;
    for (int i = 0; i < 2048; i++) font[i] = 8'h00;
    font[11'h410] = 8'h81;
    font[11'h41D] = 8'h81;
    font[11'h41E] = 8'h81;
    font[11'h41F] = 8'h81;
    vram[0] = 8'h41;

    reset_n     = 1'b0;
    cursor_en   = 1'b0;
    cursor_addr = 12'd0;
    repeat (3) @(negedge clk);
    check("rst pixel", {31'd0, pixel}, 32'd0);
    check("rst hsync_n", {31'd0, hsync_n}, 32'd1);
    check("rst vsync_n", {31'd0, vsync_n}, 32'd1);
    check("rst blank", {31'd0, blank}, 32'd1);
    check("rst video_addr", {20'd0, video_addr}, 32'd0);
    check("rst font_addr", {21'd0, font_addr}, 32'd0);
    reset_n = 1'b1;

    // Address and delayed sync/blank decode.
    for (int i = 0; i < 18; i++) begin
      preset(vecs[i].h, vecs[i].v, 0);
      check($sformatf("vec%0d video_addr", i), {20'd0, video_addr}, {20'd0, vecs[i].addr});
      repeat (4) @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d hsync_n", i), {31'd0, hsync_n}, {31'd0, vecs[i].hs});
      check($sformatf("vec%0d vsync_n", i), {31'd0, vsync_n}, {31'd0, vecs[i].vs});
      check($sformatf("vec%0d blank", i), {31'd0, blank}, {31'd0, vecs[i].bl});
    end

    // Sync pulse widths.
    preset(0, 20, 0);
    repeat (8) @(negedge clk);
    cnt0 = 0;
    for (int i = 0; i < 2400; i++) begin
      @(negedge clk);
      if (!hsync_n) cnt0++;
    end
    check("hsync low over 3 lines", cnt0, 288);

    preset(0, 486, 0);
    repeat (8) @(negedge clk);
    cnt0 = 0;
    for (int i = 0; i < 6400; i++) begin
      @(negedge clk);
      if (!vsync_n) cnt0++;
    end
    check("vsync low count", cnt0, 1600);

    preset(0, 478, 0);
    repeat (3) @(negedge clk);
    cnt0 = 0; cnt1 = 0; cnt2 = 0;
    for (int i = 0; i < 2400; i++) begin
      @(negedge clk);
      if (!blank) begin
        if (i < 800) cnt0++;
        else if (i < 1600) cnt1++;
        else cnt2++;
      end
    end
    check("blank low line 478", cnt0, 640);
    check("blank low line 479", cnt1, 640);
    check("blank low line 480", cnt2, 0);

    // Glyph, reverse video and blank text lines.
    cell_test(0, 0, 16'h8100, "glyph");
    vram[0] = 8'hC1;
    cell_test(0, 0, 16'h7E00, "reverse");
    vram[0] = 8'h41;
    cell_test(400, 0, 16'h0000, "line400");
    check("line400 blank", {31'd0, blank}, 32'd0);

    // Cursor blink and row window.
    cursor_en = 1'b1;
    cell_test(14, 16, 16'h7E00, "cur f16 l14");
    cell_test(15, 16, 16'h7E00, "cur f16 l15");
    cell_test(13, 16, 16'h8100, "cur f16 l13");
    cell_test(14, 0,  16'h8100, "cur f0 l14");
    cell_test(14, 31, 16'h7E00, "cur f31 l14");
    cell_test(14, 32, 16'h8100, "cur f32 l14");
    cursor_en = 1'b0;
    cell_test(14, 16, 16'h8100, "cur off");
    cursor_en   = 1'b1;
    cursor_addr = 12'd1;
    cell_test(14, 16, 16'h81FF, "cur cell1");
    cursor_addr = 12'd0;

    // Frame wrap feeds the blink bit.
    preset(799, 524, 15);
    repeat (1 + 14 * 800) @(posedge clk);
    @(negedge clk);
    check_cell(16'h7E00, "wrap f15->16");
    preset(799, 524, 63);
    repeat (1 + 14 * 800) @(posedge clk);
    @(negedge clk);
    check_cell(16'h8100, "wrap f63->0");
    cursor_en = 1'b0;

    // Asynchronous reset mid-frame, then restart from h=0, v=0.
    preset(290, 100, 0);
    repeat (10) @(posedge clk);
    #5;
    reset_n = 1'b0;
    #1;
    check("mid rst pixel", {31'd0, pixel}, 32'd0);
    check("mid rst hsync_n", {31'd0, hsync_n}, 32'd1);
    check("mid rst vsync_n", {31'd0, vsync_n}, 32'd1);
    check("mid rst blank", {31'd0, blank}, 32'd1);
    check("mid rst video_addr", {20'd0, video_addr}, 32'd0);
    check("mid rst font_addr", {21'd0, font_addr}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("post rst video_addr", {20'd0, video_addr}, 32'd0);
    n = 0;
    while (n < 2000 && hsync_n) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("first hsync fall cycles", n, 660);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
